// File: rtl/dcmon_pkg.sv
// Shared types and defaults for the down-counter sequence monitor.
//   dcmon_state_e : monitor FSM state, encoded INIT=0, TRACK=1, ERROR=2
//   DCMON_CW      : default monitored count width
//   DCMON_WCW     : default wrap tally width
package dcmon_pkg;

  localparam int unsigned DCMON_CW  = 4;
  localparam int unsigned DCMON_WCW = 8;

  typedef enum logic [1:0] {
    StInit  = 2'd0,
    StTrack = 2'd1,
    StError = 2'd2
  } dcmon_state_e;

endpackage

// File: rtl/downcount_monitor_if.sv
// Signal bundle between the down-counter side and the sequence monitor.
//   count_in   : count value from the upstream down counter
//   clr        : synchronous clear of wrap_cnt
//   err_ack    : acknowledge of seq_err (honoured only in ERROR)
//   wrap_pulse : one-cycle pulse per detected 0 -> all-ones wrap
//   wrap_cnt   : saturating wrap tally
//   seq_err    : sticky sequence-violation flag
//   state      : monitor FSM state
// master drives the inputs and observes results; slave is the monitor.
interface downcount_monitor_if
  import dcmon_pkg::*;
#(
  parameter int unsigned CW  = DCMON_CW,
  parameter int unsigned WCW = DCMON_WCW
) ();

  logic [CW-1:0]  count_in;
  logic           clr;
  logic           err_ack;
  logic           wrap_pulse;
  logic [WCW-1:0] wrap_cnt;
  logic           seq_err;
  dcmon_state_e   state;

  modport master (
    output count_in, clr, err_ack,
    input  wrap_pulse, wrap_cnt, seq_err, state
  );

  modport slave (
    input  count_in, clr, err_ack,
    output wrap_pulse, wrap_cnt, seq_err, state
  );

endinterface

// File: rtl/dcmon_step_chk.sv
// Combinational classifier of one count transition (prev -> cur).
//   prev       : previously sampled count
//   cur        : current count
//   is_step    : cur == prev - 1, excluding the wrap case
//   is_wrap    : prev == 0 and cur == all-ones
//   is_hold    : cur == prev
//   is_illegal : transition is a sequence violation
// Build option: DCMON_STRICT_EN makes a hold illegal (counter must move every clock).
module dcmon_step_chk #(
  parameter int unsigned CW = 4
) (
  input  logic [CW-1:0] prev,
  input  logic [CW-1:0] cur,
  output logic          is_step,
  output logic          is_wrap,
  output logic          is_hold,
  output logic          is_illegal
);

  logic [CW-1:0] prev_dec;

  always_comb begin
    // Modulo decrement: 0 - 1 naturally yields all-ones.
    prev_dec = prev - CW'(1);
    is_wrap  = (prev == '0) && (cur == '1);
    is_step  = (cur == prev_dec) && !is_wrap;
    is_hold  = (cur == prev);
`ifdef DCMON_STRICT_EN
    is_illegal = !(is_step || is_wrap);
`else
    is_illegal = !(is_step || is_wrap || is_hold);
`endif
  end

endmodule

// File: rtl/downcount_monitor.sv
// Sequence monitor for a free-running down counter.
//   clk : system clock, all state updates on its rising edge
//   rst : asynchronous active-high reset, discards all history
//   bus : downcount_monitor_if.slave (count_in, clr, err_ack in;
//         wrap_pulse, wrap_cnt, seq_err, state out)
// INIT absorbs the first sample (the counter's all-ones reset value) without checking.
// TRACK checks every transition; an illegal one enters ERROR with a sticky seq_err
// until err_ack, which resyncs to the current count.
// Build option: DCMON_STRICT_EN (see dcmon_step_chk) treats a held count as illegal.
module downcount_monitor
  import dcmon_pkg::*;
#(
  parameter int unsigned CW  = DCMON_CW,
  parameter int unsigned WCW = DCMON_WCW
) (
  input  logic               clk,
  input  logic               rst,
  downcount_monitor_if.slave bus
);

  dcmon_state_e   state_q, state_d;
  logic [CW-1:0]  prev_q, prev_d;
  logic           pulse_q, pulse_d;
  logic [WCW-1:0] cnt_q, cnt_d;
  logic           err_q, err_d;

  logic [WCW-1:0] cnt_base;
  logic           is_step, is_wrap, is_hold, is_illegal;

  dcmon_step_chk #(
    .CW(CW)
  ) u_step_chk (
    .prev       (prev_q),
    .cur        (bus.count_in),
    .is_step    (is_step),
    .is_wrap    (is_wrap),
    .is_hold    (is_hold),
    .is_illegal (is_illegal)
  );

  always_comb begin
    state_d  = state_q;
    prev_d   = bus.count_in;  // prev tracks the input in every state
    pulse_d  = 1'b0;
    err_d    = err_q;
    // clr wins over the old tally but a same-edge wrap still counts from zero.
    cnt_base = bus.clr ? '0 : cnt_q;
    cnt_d    = cnt_base;

    unique case (state_q)
      StInit: begin
        state_d = StTrack;
      end
      StTrack: begin
        if (is_illegal) begin
          state_d = StError;
          err_d   = 1'b1;
        end else if (is_wrap) begin
          pulse_d = 1'b1;
          cnt_d   = (cnt_base == '1) ? cnt_base : cnt_base + WCW'(1);
        end
      end
      StError: begin
        if (bus.err_ack) begin
          state_d = StTrack;
          err_d   = 1'b0;
        end
      end
      default: begin
        state_d = StInit;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StInit;
      prev_q  <= '0;
      pulse_q <= 1'b0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      prev_q  <= prev_d;
      pulse_q <= pulse_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  assign bus.wrap_pulse = pulse_q;
  assign bus.wrap_cnt   = cnt_q;
  assign bus.seq_err    = err_q;
  assign bus.state      = state_q;

endmodule

// File: tb/tb_downcount_monitor.sv
module tb_downcount_monitor;
  import dcmon_pkg::*;

`ifdef DCMON_STRICT_EN
  localparam bit Strict = 1'b1;
`else
  localparam bit Strict = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_a = 1'b0;
  logic rst_b = 1'b0;
  always #5 clk = ~clk;

  downcount_monitor_if #(.CW(4), .WCW(8)) bus_a ();
  downcount_monitor_if #(.CW(4), .WCW(2)) bus_b ();

  downcount_monitor #(.CW(4), .WCW(8)) dut_a (
    .clk (clk),
    .rst (rst_a),
    .bus (bus_a.slave)
  );

  downcount_monitor #(.CW(4), .WCW(2)) dut_b (
    .clk (clk),
    .rst (rst_b),
    .bus (bus_b.slave)
  );

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [3:0] cin;
    logic       clr;
    logic       ack;
    logic       pulse;
    int         cnt;
    logic       err;
    int         st;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic void add(input int cin, input bit clr, input bit ack, input bit pulse,
                              input int cnt, input bit err, input int st);
    vec_t v;
    v.cin = 4'(cin); v.clr = clr; v.ack = ack;
    v.pulse = pulse; v.cnt = cnt; v.err = err; v.st = st;
    vecs.push_back(v);
  endfunction

  task automatic drive_a(input int cin, input bit clr, input bit ack);
    bus_a.count_in = 4'(cin);
    bus_a.clr      = clr;
    bus_a.err_ack  = ack;
  endtask

  // One full wrap on dut_a starting from prev=0: F (wrap edge) then E..0.
  task automatic wrap_a(input int exp_cnt);
    drive_a(15, 0, 0);
    tick();
    chk("wrap_a.pulse", int'(bus_a.wrap_pulse), 1);
    chk("wrap_a.cnt", int'(bus_a.wrap_cnt), exp_cnt);
    for (int v = 14; v >= 0; v--) begin
      drive_a(v, 0, 0);
      tick();
      if (v == 14) chk("wrap_a.pulse_off", int'(bus_a.wrap_pulse), 0);
    end
  endtask

  initial begin
    int npulse;
    int p0;
    int p1;
    drive_a(15, 0, 0);
    bus_b.count_in = 4'd0;
    bus_b.clr      = 1'b0;
    bus_b.err_ack  = 1'b0;
    #1 rst_a = 1'b1;
    rst_b = 1'b1;
    #10;
    chk("reset.pulse", int'(bus_a.wrap_pulse), 0);
    chk("reset.cnt", int'(bus_a.wrap_cnt), 0);
    chk("reset.err", int'(bus_a.seq_err), 0);
    chk("reset.state", int'(bus_a.state), 0);
    rst_a = 1'b0;

    // Vector table: inputs for one edge, outputs expected just after it.
    add(15, 0, 0, 0, 0, 0, 1);                 // INIT absorbs F
    for (int v = 14; v >= 0; v--) add(v, 0, 0, 0, 0, 0, 1);
    add(15, 0, 0, 1, 1, 0, 1);                 // 0 -> F wrap
    add(14, 0, 0, 0, 1, 0, 1);
    for (int v = 13; v >= 9; v--) add(v, 0, 0, 0, 1, 0, 1);
    add(4, 0, 0, 0, 1, 1, 2);                  // 9 -> 4 jump
    add(3, 0, 0, 0, 1, 1, 2);
    add(7, 0, 0, 0, 1, 1, 2);
    add(0, 0, 0, 0, 1, 1, 2);
    add(15, 0, 0, 0, 1, 1, 2);                 // no wrap detection in ERROR
    add(2, 0, 0, 0, 1, 1, 2);
    add(2, 0, 1, 0, 1, 0, 1);                  // ack with count 2: resync
    add(1, 0, 0, 0, 1, 0, 1);
    add(0, 0, 0, 0, 1, 0, 1);
    add(15, 0, 0, 1, 2, 0, 1);
    for (int v = 14; v >= 6; v--) add(v, 0, 0, 0, 2, 0, 1);
    for (int k = 0; k < 3; k++) add(6, 0, 0, 0, 2, Strict, Strict ? 2 : 1);
    add(5, 0, 0, 0, 2, Strict, Strict ? 2 : 1);
    add(4, 0, 1, 0, 2, 0, 1);                  // both builds converge in TRACK

    foreach (vecs[i]) begin
      drive_a(int'(vecs[i].cin), vecs[i].clr, vecs[i].ack);
      tick();
      chk($sformatf("vec%0d.pulse", i), int'(bus_a.wrap_pulse), int'(vecs[i].pulse));
      chk($sformatf("vec%0d.cnt", i), int'(bus_a.wrap_cnt), vecs[i].cnt);
      chk($sformatf("vec%0d.err", i), int'(bus_a.seq_err), int'(vecs[i].err));
      chk($sformatf("vec%0d.state", i), int'(bus_a.state), vecs[i].st);
    end

    // Free-running upstream counter for 40 cycles from a fresh reset.
    rst_a = 1'b1;
    #1 rst_a = 1'b0;
    npulse = 0;
    p0 = -1;
    p1 = -1;
    for (int i = 0; i < 40; i++) begin
      drive_a(15 - (i % 16), 0, 0);
      tick();
      if (bus_a.wrap_pulse) begin
        if (npulse == 0) p0 = i;
        if (npulse == 1) p1 = i;
        npulse++;
      end
    end
    chk("free.npulse", npulse, 2);
    chk("free.first_pulse", p0, 16);
    chk("free.second_pulse", p1, 32);
    chk("free.cnt", int'(bus_a.wrap_cnt), 2);
    chk("free.err", int'(bus_a.seq_err), 0);
    chk("free.state", int'(bus_a.state), 1);

    // Async reset in the middle of ERROR with wrap_cnt=4.
    rst_a = 1'b1;
    #1 rst_a = 1'b0;
    drive_a(0, 0, 0);
    tick();
    for (int w = 1; w <= 4; w++) wrap_a(w);
    drive_a(5, 0, 0);
    tick();
    chk("err4.state", int'(bus_a.state), 2);
    chk("err4.err", int'(bus_a.seq_err), 1);
    chk("err4.cnt", int'(bus_a.wrap_cnt), 4);
    #2 rst_a = 1'b1;
    #1;
    chk("arst.pulse", int'(bus_a.wrap_pulse), 0);
    chk("arst.cnt", int'(bus_a.wrap_cnt), 0);
    chk("arst.err", int'(bus_a.seq_err), 0);
    chk("arst.state", int'(bus_a.state), 0);
    #1 rst_a = 1'b0;

    // clr on the same edge as a wrap with wrap_cnt=7.
    drive_a(0, 0, 0);
    tick();
    chk("clr.init_state", int'(bus_a.state), 1);
    for (int w = 1; w <= 7; w++) wrap_a(w);
    chk("clr.pre_cnt", int'(bus_a.wrap_cnt), 7);
    drive_a(15, 1, 0);
    tick();
    chk("clr.wrap_cnt", int'(bus_a.wrap_cnt), 1);
    chk("clr.wrap_pulse", int'(bus_a.wrap_pulse), 1);
    drive_a(14, 0, 1);                         // err_ack in TRACK is ignored
    tick();
    chk("clr.after_pulse", int'(bus_a.wrap_pulse), 0);
    chk("clr.after_state", int'(bus_a.state), 1);
    drive_a(13, 1, 0);
    tick();
    chk("clr.plain", int'(bus_a.wrap_cnt), 0);
    chk("clr.err", int'(bus_a.seq_err), 0);

    // WCW=2 instance: 5 wraps, tally saturates at 3, every wrap pulses.
    rst_b = 1'b0;
    bus_b.count_in = 4'd0;
    tick();
    npulse = 0;
    for (int w = 1; w <= 5; w++) begin
      bus_b.count_in = 4'd15;
      tick();
      if (bus_b.wrap_pulse) npulse++;
      chk($sformatf("sat.cnt%0d", w), int'(bus_b.wrap_cnt), (w < 3) ? w : 3);
      for (int v = 14; v >= 0; v--) begin
        bus_b.count_in = 4'(v);
        tick();
        if (bus_b.wrap_pulse) npulse++;
      end
    end
    chk("sat.npulse", npulse, 5);
    chk("sat.err", int'(bus_b.seq_err), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/downcount_monitor.md
Name: downcount_monitor

Overview:
- Sits directly downstream of the 4-bit down counter and consumes its count output on the same clock.
- Checks that the count sequence is legal: each new value equals the previous value, or the previous value minus 1 modulo 2^CW.
- Detects underflow wrap-around (0 -> all-ones), emits a one-cycle wrap pulse and keeps a saturating wrap tally.
- Flags sequence violations with a sticky error and an acknowledge handshake.

Parameters:
- CW, 4, width of the monitored count.
- WCW, 8, width of the wrap tally.

Ports:
- clk  input  1  single system clock; all state updates on its rising edge.
- rst  input  1  asynchronous, active-high reset.
- count_in  input  CW  count value from the upstream down counter.
- clr  input  1  synchronous clear of wrap_cnt.
- err_ack  input  1  acknowledges seq_err; honoured only in state ERROR.
- wrap_pulse  output  1  registered; high for exactly one cycle per detected wrap.
- wrap_cnt  output  WCW  number of wraps seen, saturating at 2^WCW-1.
- seq_err  output  1  sticky sequence-violation flag.
- state  output  2  current FSM state: INIT=0, TRACK=1, ERROR=2.

Behaviour:
- Reset (async, immediate on rst high): state=INIT, prev_q=0, wrap_pulse=0, wrap_cnt=0, seq_err=0. rst mid-operation discards all history.
- INIT: on the first clk edge with rst low, prev_q<=count_in and state<=TRACK. No checks are made and no outputs change.
- TRACK: every edge compares count_in with prev_q, then sets prev_q<=count_in.
  - count_in == prev_q-1 (mod 2^CW): legal step.
  - prev_q==0 and count_in=={CW{1}}: legal wrap. wrap_pulse<=1 for the next cycle only, and wrap_cnt increments with saturation.
  - count_in == prev_q (hold): legal by default (see Optional Feature).
  - Any other value: state<=ERROR and seq_err<=1 at that edge. wrap_cnt is unchanged.
- ERROR: seq_err stays 1 and no checks are made. prev_q still tracks count_in every edge.
  - err_ack=1 at an edge: state<=TRACK, seq_err<=0, prev_q<=count_in (resync). The first check is made at the following edge.
  - err_ack in INIT or TRACK is ignored.
- Latency: a violation or wrap observed on count_in before edge N is reflected on the outputs immediately after edge N (1 cycle).
- clr=1 at an edge: wrap_cnt<=0. If a wrap is detected at the same edge, wrap_cnt<=1 and wrap_pulse still fires. clr never affects seq_err or state.
- Saturation: at wrap_cnt=2^WCW-1, further wraps still pulse wrap_pulse; wrap_cnt holds.
- A wrap and an error cannot coincide, because a wrap is by definition a legal step.
- The upstream counter resets to all-ones. INIT absorbs this value, so no false error or wrap is reported after reset.

Optional Feature:
- Macro DCMON_STRICT_EN.
- Defined: a hold (count_in == prev_q) in TRACK is a sequence violation (state<=ERROR, seq_err<=1). Use this when the upstream counter decrements every clock.
- Undefined: a hold is legal and silently accepted.
- All other behaviour is identical in both builds.

Decomposition:
- Package dcmon_pkg holds:
  - the state typedef (2-bit enum INIT/TRACK/ERROR) and its encodings;
  - default constants DCMON_CW=4 and DCMON_WCW=8.
- One sub-module, dcmon_step_chk: combinational classifier of (prev_q, count_in) into step/wrap/hold/illegal. The hold-as-illegal choice under DCMON_STRICT_EN lives there.
- The FSM, tally and output registers stay in the top module.

Test Plan:
- Reset, then feed F,E,...,1,0,F: wrap_pulse high exactly one cycle after the 0->F edge; wrap_cnt=1; seq_err=0; state=TRACK.
- Free-running upstream counter for 40 cycles: wrap_cnt=2 after the second 0->F wrap; no seq_err.
- Inject a jump 9 -> 4: seq_err=1 and state=ERROR the next cycle. Keep err_ack=0 for 5 cycles: both hold. Pulse err_ack with count_in=2: TRACK, seq_err=0, then 1 is accepted as legal.
- Assert clr on the same edge as a 0->F wrap with wrap_cnt=7: wrap_cnt=1 and wrap_pulse=1. With WCW=2, drive 5 wraps: wrap_cnt saturates at 3 and all 5 pulses occur.
- Hold count_in at 6 for 3 cycles: no error without DCMON_STRICT_EN; with DCMON_STRICT_EN, seq_err=1 one cycle after the first hold.
- Assert rst asynchronously mid-ERROR with wrap_cnt=4: all outputs are 0 and state=INIT immediately, before the next clk edge.
